// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register stage with flush and asynchronous reset.
// Define PIPE_STAGE_SKID_EN to build the two-entry skid variant with a registered in_ready.
module pipe_stage_reg #(
    parameter int unsigned    W       = 32,
    parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic accept;
    logic emit;

`ifdef PIPE_STAGE_SKID_EN

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } skidStateT;

    skidStateT      stateQ;
    logic [W-1:0]   mainQ;
    logic [W-1:0]   skidQ;
    logic           inReadyQ;
    logic           outValidQ;

    // in_ready comes straight from a flop so out_ready never reaches it combinationally.
    assign in_ready  = inReadyQ;
    assign out_valid = outValidQ;
    assign out_data  = mainQ;

    assign accept = in_valid && inReadyQ;
    assign emit   = outValidQ && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= StEmpty;
            mainQ     <= RST_VAL;
            skidQ     <= RST_VAL;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
        end else if (flush) begin
            stateQ    <= StEmpty;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
        end else begin
            unique case (stateQ)
                StEmpty: begin
                    if (accept) begin
                        mainQ     <= in_data;
                        stateQ    <= StOne;
                        outValidQ <= 1'b1;
                    end
                end
                StOne: begin
                    if (accept && !emit) begin
                        skidQ    <= in_data;
                        stateQ   <= StTwo;
                        inReadyQ <= 1'b0;
                    end else if (emit && !accept) begin
                        stateQ    <= StEmpty;
                        outValidQ <= 1'b0;
                    end else if (accept && emit) begin
                        mainQ <= in_data;
                    end
                end
                StTwo: begin
                    // Older payload leaves first; the skid entry moves up to main.
                    if (emit) begin
                        mainQ    <= skidQ;
                        stateQ   <= StOne;
                        inReadyQ <= 1'b1;
                    end
                end
                default: begin
                    stateQ    <= StEmpty;
                    inReadyQ  <= 1'b1;
                    outValidQ <= 1'b0;
                end
            endcase
        end
    end

`else

    logic           validQ;
    logic [W-1:0]   dataQ;

    assign in_ready  = out_ready || !validQ;
    assign out_valid = validQ;
    assign out_data  = dataQ;

    assign accept = in_valid && in_ready;
    assign emit   = validQ && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validQ <= 1'b0;
            dataQ  <= RST_VAL;
        end else begin
            if (flush) begin
                validQ <= 1'b0;
            end else if (accept) begin
                validQ <= 1'b1;
            end else if (emit) begin
                validQ <= 1'b0;
            end
            // Payload may load during a flush; it is never presented since valid drops.
            if (accept) begin
                dataQ <= in_data;
            end
        end
    end

`endif

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter W, 32, payload width in bits (1..512).
REQ-002 Parameter RST_VAL, {W{1'b0}}, value loaded into payload registers on reset.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 clk  input  1  stage clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 flush  input  1  synchronous kill of all held and incoming entries.
REQ-007 in_valid  input  1  upstream presents a payload.
REQ-008 in_ready  output  1  stage accepts a payload this cycle.
REQ-009 in_data  input  W  upstream payload.
REQ-010 out_valid  output  1  stage presents a payload downstream.
REQ-011 out_ready  input  1  downstream accepts a payload this cycle.
REQ-012 out_data  output  W  payload presented downstream.

Function
REQ-013 Accept SHALL occur when in_valid && in_ready at a rising edge; emit SHALL occur when out_valid && out_ready at a rising edge.
REQ-014 Latency SHALL be exactly 1 cycle from accept to out_valid with an empty stage; payloads SHALL leave in acceptance order, none lost or duplicated.
REQ-015 out_data SHALL hold stable while out_valid && !out_ready.
REQ-016 Simultaneous accept and emit with one entry held SHALL replace the entry in the same edge; throughput SHALL be 1 payload per cycle when out_ready stays high.
REQ-017 flush SHALL, at the edge, clear every valid bit and discard any payload accepted at that edge; out_valid SHALL be 0 the next cycle; payload registers need not change.
REQ-018 flush SHALL take priority over accept and emit at the same edge; in_ready value during flush follows the normal rule, accepted data is dropped.
REQ-019 in_valid while in_ready is low SHALL have no effect; upstream keeps in_data stable.

Reset
REQ-020 While rst=1: out_valid=0, out_data=RST_VAL, all internal valid bits 0, skid state EMPTY (when present).
REQ-021 in_ready SHALL be 1 during and immediately after reset in both configurations.
REQ-022 Reset asserted mid-transfer SHALL abandon held payloads without emitting them; first accept after release SHALL be the first emitted.

Configuration
REQ-023 Macro PIPE_STAGE_SKID_EN selects the ready path.
REQ-024 Without PIPE_STAGE_SKID_EN: one entry; in_ready = out_ready || !out_valid (combinational from out_ready).
REQ-025 With PIPE_STAGE_SKID_EN: main + skid entries; in_ready SHALL be a register output with no combinational path from out_ready.
REQ-026 Skid FSM states EMPTY (no entry), ONE (main valid), TWO (main+skid valid); in_ready = (state != TWO).
REQ-027 Transitions: EMPTY-accept->ONE; ONE-accept&!emit->TWO (payload to skid); ONE-emit&!accept->EMPTY; ONE-accept&emit->ONE; TWO-emit->ONE (skid moves to main); flush from any state->EMPTY.
REQ-028 In TWO, out_data SHALL show the older (main) payload; skid payload emits on the following emit.

Verification
REQ-029 Stream: out_ready=1, in_data=0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later, out_valid high 3 cycles.
REQ-030 Backpressure: accept 0xA, out_ready=0 for 4 cycles -> out_data=0xA stable; no-skid in_ready=0 after 1st accept; skid build accepts 0xB then in_ready=0; release -> 0xA then 0xB emitted.
REQ-031 Flush: held 0xC, in_valid=1 data 0xD, flush=1 -> next cycle out_valid=0; 0xC, 0xD never emitted.
REQ-032 Async reset: rst pulsed mid-cycle while out_valid=1 -> out_valid=0 and out_data=RST_VAL immediately, before next clk edge; in_ready=1.
REQ-033 Random: 10k cycles random in_valid/out_ready/flush at W=7 and W=128, both macro settings -> scoreboard order match, no loss/duplication except flushed entries.
REQ-034 Skid timing: with PIPE_STAGE_SKID_EN, toggling out_ready alone SHALL not change in_ready until the next clk edge.
